// File: rtl/uart_receiver_if.sv
// Signal bundle between the 8N1 UART receiver and its consumer.
// The master modport is the receiver. The slave modport is the controller or the line driver.
interface uart_receiver_if;
  logic       UART_RX;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       FRAME_ERR;
  logic [2:0] dbg_state;

  // RX_STATUS and FRAME_ERR are single-clk strobes with no ready/back-pressure:
  // RX_DATA is valid from the RX_STATUS clk until the next RX_STATUS, and the
  // consumer must take it in that window; FRAME_ERR carries no data.
  modport master (
    input  UART_RX,
    output RX_DATA, RX_STATUS, FRAME_ERR, dbg_state
  );

  modport slave (
    output UART_RX,
    input  RX_DATA, RX_STATUS, FRAME_ERR, dbg_state
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: 2-flop synchronizer, oversampling prescaler,
// 3-sample majority vote per bit, byte strobe and frame-error strobe.
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_receiver_if.master  bus
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [TW-1:0] T_MAX     = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_A       = TW'(M - 1);
  localparam logic [TW-1:0] T_B       = TW'(M);
  localparam logic [TW-1:0] T_C       = TW'(M + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [PW-1:0] presc;
  logic [TW-1:0] t_cnt;
  logic [2:0]    bit_idx;
  logic          samp_a;
  logic          samp_b;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data;
  logic          rx_status;
  logic          frame_err;

  logic tick;
  logic vote_tick;
  logic vote;

  assign tick      = (state != IDLE) && (presc == PRESC_MAX);
  // The third sample is rx_s itself on the t=M+1 tick, so the vote resolves there.
  assign vote_tick = tick && (t_cnt == T_C);
  assign vote      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      presc     <= '0;
      t_cnt     <= '0;
      bit_idx   <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      shift_q   <= 8'h00;
      rx_data   <= 8'h00;
      rx_status <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= bus.UART_RX;
      rx_s      <= rx_meta;
      rx_status <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE) begin
        presc   <= '0;
        t_cnt   <= '0;
        bit_idx <= '0;
        if (!rx_s) state <= START;
      end else begin
        if (tick) begin
          presc <= '0;
          t_cnt <= (t_cnt == T_MAX) ? '0 : t_cnt + TW'(1);
        end else begin
          presc <= presc + PW'(1);
        end
        if (tick && t_cnt == T_A) samp_a <= rx_s;
        if (tick && t_cnt == T_B) samp_b <= rx_s;

        case (state)
          // A start bit that votes high was a glitch; the start bit otherwise runs to its end.
          START: begin
            if (vote_tick && vote) begin
              state <= IDLE;
            end else if (tick && t_cnt == T_MAX) begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
          DATA: begin
            if (vote_tick) shift_q <= {vote, shift_q[7:1]};
            if (tick && t_cnt == T_MAX) begin
              if (bit_idx == 3'd7) state <= STOP;
              else                 bit_idx <= bit_idx + 3'd1;
            end
          end
          // Decided mid stop bit so a start bit right after the stop bit is not missed.
          STOP: begin
            if (vote_tick) begin
              if (vote) begin
                rx_data   <= shift_q;
                rx_status <= 1'b1;
                state     <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BRK;
              end
            end
          end
          BRK: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.RX_DATA   = rx_data;
  assign bus.RX_STATUS = rx_status;
  assign bus.FRAME_ERR = frame_err;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: DIV=2, 32 clk per bit, byte scoreboard on RX_STATUS.
module tb_uart_receiver;

  localparam int CLK_FREQ   = 3200;
  localparam int BAUD_RATE  = 100;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = 32;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BRK  = 3'd4;

  logic clk;
  logic reset;

  uart_receiver_if bus ();

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int status_cnt = 0;
  int ferr_cnt   = 0;
  int viol_cnt   = 0;
  int unexp_cnt  = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard / strobe monitor
  always @(negedge clk) begin
    if (bus.RX_STATUS && bus.FRAME_ERR) viol_cnt++;
    if ((bus.RX_STATUS || bus.FRAME_ERR) && prev_pulse) viol_cnt++;
    prev_pulse = bus.RX_STATUS || bus.FRAME_ERR;
    if (bus.RX_STATUS) begin
      status_cnt++;
      if (exp_q.size() > 0) check("rx_data", {24'h0, bus.RX_DATA}, {24'h0, exp_q.pop_front()});
      else unexp_cnt++;
    end
    if (bus.FRAME_ERR) ferr_cnt++;
  end

  // drivers
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    bus.UART_RX = v;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int glitch_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        bus.UART_RX = d[i];
        wait_clks(16);
        bus.UART_RX = ~d[i];
        wait_clks(2);
        bus.UART_RX = d[i];
        wait_clks(BIT_CLKS - 18);
      end else begin
        send_bit(d[i]);
      end
    end
    send_bit(stop_v);
  endtask

  logic [7:0] abort_byte;

  initial begin
    bus.UART_RX = 1'b1;
    reset       = 1'b0;
    wait_clks(5);
    check("reset_rx_data",   {24'h0, bus.RX_DATA},   32'h00);
    check("reset_rx_status", {31'h0, bus.RX_STATUS}, 32'h0);
    check("reset_frame_err", {31'h0, bus.FRAME_ERR}, 32'h0);
    check("reset_state",     {29'h0, bus.dbg_state}, {29'h0, S_IDLE});
    reset = 1'b1;
    wait_clks(10);
    check("idle_state", {29'h0, bus.dbg_state}, {29'h0, S_IDLE});

    // 1: single byte
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, -1);
    wait_clks(20);
    check("t1_status_cnt", status_cnt, 1);
    check("t1_ferr_cnt",   ferr_cnt,   0);
    check("t1_rx_data",    {24'h0, bus.RX_DATA}, 32'h55);

    // 2: back-to-back frames
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    wait_clks(20);
    check("t2_status_cnt", status_cnt, 3);
    check("t2_rx_data",    {24'h0, bus.RX_DATA}, 32'h0F);

    // 3: short low glitch
    bus.UART_RX = 1'b0;
    wait_clks(6);
    bus.UART_RX = 1'b1;
    wait_clks(60);
    check("t3_status_cnt", status_cnt, 3);
    check("t3_ferr_cnt",   ferr_cnt,   0);
    check("t3_state",      {29'h0, bus.dbg_state}, {29'h0, S_IDLE});

    // 4: framing error followed by a held-low line
    send_frame(8'h3C, 1'b0, -1);
    wait_clks(100);
    check("t4_ferr_cnt",   ferr_cnt,   1);
    check("t4_status_cnt", status_cnt, 3);
    check("t4_rx_data",    {24'h0, bus.RX_DATA}, 32'h0F);
    check("t4_brk_state",  {29'h0, bus.dbg_state}, {29'h0, S_BRK});
    bus.UART_RX = 1'b1;
    wait_clks(40);
    check("t4_idle_state", {29'h0, bus.dbg_state}, {29'h0, S_IDLE});
    check("t4_ferr_final", ferr_cnt, 1);

    // 5: single-sample glitch in bit 3
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 3);
    wait_clks(20);
    check("t5_status_cnt", status_cnt, 4);
    check("t5_rx_data",    {24'h0, bus.RX_DATA}, 32'hFF);

    // 6: reset during bit 4 of 0x81, then 0x7E
    abort_byte = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(abort_byte[i]);
    bus.UART_RX = abort_byte[4];
    wait_clks(10);
    reset = 1'b0;
    wait_clks(3);
    bus.UART_RX = 1'b1;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(40);
    check("t6_rx_data_rst", {24'h0, bus.RX_DATA}, 32'h00);
    check("t6_state_rst",   {29'h0, bus.dbg_state}, {29'h0, S_IDLE});
    check("t6_status_rst",  status_cnt, 4);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, -1);
    wait_clks(20);
    check("t6_status_cnt", status_cnt, 5);
    check("t6_ferr_cnt",   ferr_cnt,   1);
    check("t6_rx_data",    {24'h0, bus.RX_DATA}, 32'h7E);

    // final report
    check("strobe_rules",  viol_cnt,  0);
    check("unexp_status",  unexp_cnt, 0);
    check("exp_q_left",    exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
